// File: rtl/alu_flags16_pkg.sv
// Shared definitions for the alu_flags16 execute-stage ALU: opcode encodings,
// default datapath width and the packed status-flag layout.
package alu_flags16_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Bit order matches the top-level flag ports so status registers can copy it as-is.
  typedef struct packed {
    logic s;
    logic z;
    logic p;
    logic cout;
    logic ov;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{s: 1'b0, z: 1'b1, p: 1'b1, cout: 1'b0, ov: 1'b0};

endpackage

// File: rtl/alu_flags16_core.sv
// Combinational ALU core: produces the result word, carry-out and signed
// overflow for one operation. Sign/zero/parity are derived by the caller.
module alu_flags16_core
  import alu_flags16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ov
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    cout   = 1'b0;
    ov     = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
        ov     = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
        ov     = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        cout   = a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        cout   = a[0];
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_flags16.sv
// Registered 16-bit ALU with sign/zero/parity/carry/overflow flags and a
// one-cycle out_valid pulse per accepted operation.
module alu_flags16
  import alu_flags16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             S,
  output logic             Z,
  output logic             P,
  output logic             Cout,
  output logic             Ov,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_result;
  logic             core_cout;
  logic             core_ov;
  flags_t           next_flags;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             valid_q;

  alu_flags16_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op    (op),
    .a     (A),
    .b     (B),
    .result(core_result),
    .cout  (core_cout),
    .ov    (core_ov)
  );

  always_comb begin
    next_flags.s    = core_result[WIDTH-1];
    next_flags.z    = (core_result == '0);
    next_flags.p    = ~^core_result;
    next_flags.cout = core_cout;
    next_flags.ov   = core_ov;
  end

  // Result and flags only move on an accepted operation; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= FLAGS_RESET;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= core_result;
        flags_q  <= next_flags;
      end
    end
  end

  assign C         = result_q;
  assign S         = flags_q.s;
  assign Z         = flags_q.z;
  assign P         = flags_q.p;
  assign Cout      = flags_q.cout;
  assign Ov        = flags_q.ov;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_flags16.sv
// Self-checking bench for alu_flags16: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_flags16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic        S;
  logic        Z;
  logic        P;
  logic        Cout;
  logic        Ov;
  logic        out_valid;

  int checks = 0;
  int passes = 0;

  alu_flags16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .A        (A),
    .B        (B),
    .C        (C),
    .S        (S),
    .Z        (Z),
    .P        (P),
    .Cout     (Cout),
    .Ov       (Ov),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {C, S, Z, P, Cout, Ov} from integer arithmetic on the operands.
  function automatic logic [20:0] ref_model(input logic [2:0] f_op, input logic [15:0] a,
                                            input logic [15:0] b);
    int          ua;
    int          ub;
    int          sa;
    int          sb;
    int          full;
    int          sres;
    logic [15:0] c;
    logic        cy;
    logic        ovf;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    cy   = 1'b0;
    ovf  = 1'b0;
    full = 0;
    sres = 0;
    case (f_op)
      3'd0: begin
        full = ua + ub;
        c    = full[15:0];
        cy   = (full > 65535);
        sres = sa + sb;
        ovf  = (sres > 32767) || (sres < -32768);
      end
      3'd1: begin
        full = ua - ub;
        c    = full[15:0];
        cy   = (ua >= ub);
        sres = sa - sb;
        ovf  = (sres > 32767) || (sres < -32768);
      end
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = a ^ b;
      3'd5: c = ~a;
      3'd6: begin
        full = ua * 2;
        c    = full[15:0];
        cy   = (ua >= 32768);
      end
      default: begin
        full = ua / 2;
        c    = full[15:0];
        cy   = (ua % 2) == 1;
      end
    endcase
    return {c, c >= 16'h8000, c == 16'h0000, ($countones(c) % 2) == 0, cy, ovf};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Drives one operation, then checks the registered outputs after the accepting edge.
  task automatic apply_stimulus(input string tag, input logic [2:0] s_op, input logic [15:0] a,
                                input logic [15:0] b, input logic check_c,
                                input logic [15:0] exp_c);
    logic [20:0] exp;
    @(negedge clk);
    in_valid = 1'b1;
    op       = s_op;
    A        = a;
    B        = b;
    exp      = ref_model(s_op, a, b);
    @(posedge clk);
    #1;
    if (check_c) check_output({tag, "_c_const"}, 32'(C), 32'(exp_c));
    check_output({tag, "_out"}, 32'({C, S, Z, P, Cout, Ov}), 32'(exp));
    check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic idle_hold(input string tag, input int cycles, input logic [20:0] exp);
    @(negedge clk);
    in_valid = 1'b0;
    A        = 16'($urandom);
    B        = 16'($urandom);
    op       = 3'($urandom);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_output({tag, "_hold"}, 32'({C, S, Z, P, Cout, Ov}), 32'(exp));
      check_output({tag, "_novalid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [20:0] reset_vec;
    logic [20:0] last;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    reset_vec = {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    A         = 16'h0;
    B         = 16'h0;
    #12;
    check_output("reset_out", 32'({C, S, Z, P, Cout, Ov}), 32'(reset_vec));
    check_output("reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("add0", 3'd0, 16'h0348, 16'h354E, 1'b1, 16'h3896);
    idle_hold("add0", 1, {16'h3896, 5'b00000});
    apply_stimulus("add1", 3'd0, 16'h0125, 16'h25FE, 1'b1, 16'h2723);
    apply_stimulus("add2", 3'd0, 16'h34CD, 16'hEF12, 1'b1, 16'h23DF);
    apply_stimulus("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000);
    apply_stimulus("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000);
    apply_stimulus("sub_ovf", 3'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF);
    apply_stimulus("sub_borrow", 3'd1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF);
    apply_stimulus("and", 3'd2, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0);
    apply_stimulus("or", 3'd3, 16'hF0F0, 16'h0FF0, 1'b1, 16'hFFF0);
    apply_stimulus("xor", 3'd4, 16'hF0F0, 16'h0FF0, 1'b1, 16'hFF00);
    apply_stimulus("not", 3'd5, 16'hF0F0, 16'h0FF0, 1'b1, 16'h0F0F);
    apply_stimulus("shl", 3'd6, 16'hF0F0, 16'h0FF0, 1'b1, 16'hE1E0);
    apply_stimulus("shr", 3'd7, 16'hF0F0, 16'h0FF0, 1'b1, 16'h7878);
    idle_hold("shr", 3, {16'h7878, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    last = '0;
    for (int i = 0; i < 300; i++) begin
      r_op = 3'($urandom);
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      if (i % 16 == 0) r_b = r_a;
      if (i % 23 == 0) r_a = 16'h8000;
      apply_stimulus("rand", r_op, r_a, r_b, 1'b0, 16'h0);
      last = ref_model(r_op, r_a, r_b);
      if (i % 37 == 0) idle_hold("rand", 2, last);
    end

    // Assert reset between edges while an operation is being presented.
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd0;
    A        = 16'h1234;
    B        = 16'h4321;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst_out", 32'({C, S, Z, P, Cout, Ov}), 32'(reset_vec));
    check_output("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("rst_held_out", 32'({C, S, Z, P, Cout, Ov}), 32'(reset_vec));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle_hold("post_rst", 3, reset_vec);

    apply_stimulus("after_rst", 3'd1, 16'h0005, 16'h0003, 1'b1, 16'h0002);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_flags16.md
Name: alu_flags16

Overview:
- Registered 16-bit ALU that produces a result word plus five status flags: sign, zero, parity, carry-out and signed overflow.
- Sits in the datapath execute stage: operands and opcode are sampled on one clock edge; result and flags are registered and held until the next accepted operation.
- Opcode 000 (ADD) is the primary operation; the remaining opcodes extend the block to a small general ALU.

Parameters:
- WIDTH, 16, operand/result width in bits; all flag rules below generalise with MSB = WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies A, B, op in this cycle
- op  input  3  operation select
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- C  output  WIDTH  registered result
- S  output  1  sign flag = C[WIDTH-1]
- Z  output  1  zero flag, 1 when C == 0
- P  output  1  parity flag, 1 when C has an even number of 1s (XNOR-reduce)
- Cout  output  1  carry-out
- Ov  output  1  signed overflow
- out_valid  output  1  1-cycle pulse, outputs updated this cycle

Behaviour:
- Reset (rst_n low, asynchronous): C=0, S=0, Z=1, P=1, Cout=0, Ov=0, out_valid=0. Flags are consistent with C=0. Reset is held while rst_n is low; release is synchronous to the next edge.
- Latency 1: in_valid high at edge N causes C and flags to be registered at edge N; out_valid is high for the cycle following edge N.
- in_valid low: C and flags hold their values; out_valid=0.
- Back-to-back in_valid is accepted every cycle; there is no backpressure.
- Reset asserted mid-operation discards the pending result.
- Opcodes:
  - 000 ADD: {Cout,C} = A + B (WIDTH+1 bits); Ov = (A[msb]==B[msb]) && (C[msb]!=A[msb]).
  - 001 SUB: C = A + ~B + 1; Cout = carry of that sum (1 means no borrow); Ov = (A[msb]!=B[msb]) && (C[msb]!=A[msb]).
  - 010 AND, 011 OR, 100 XOR: bitwise on A and B; Cout=0, Ov=0.
  - 101 NOT: C = ~A; B is ignored; Cout=0, Ov=0.
  - 110 SHL: C = A<<1 with zero fill; Cout = A[msb]; Ov=0.
  - 111 SHR: logical shift, C = A>>1 with zero fill; Cout = A[0]; Ov=0.
- S, Z and P are always derived from the new C, for every opcode, and registered together with C.
- Arithmetic wraps modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package holds:
  - the op encoding constants (OP_ADD..OP_SHR);
  - the default WIDTH;
  - a flag-bit index typedef/struct {S,Z,P,Cout,Ov} for reuse by downstream status registers.
- One combinational sub-module, alu_flags16_core, computes the result, Cout and Ov. The top level adds the S/Z/P derivation, the registers, reset and out_valid.

Test Plan:
- ADD A=0x0348, B=0x354E -> C=0x3896, S=0, Z=0, P=0, Cout=0, Ov=0; out_valid pulses one cycle after the accepting edge.
- ADD A=0x0125, B=0x25FE -> C=0x2723, S=0, Z=0, P=0, Cout=0, Ov=0. Then ADD A=0x34CD, B=0xEF12 -> C=0x23DF, S=0, Z=0, P=1, Cout=1, Ov=0.
- ADD 0x7FFF+0x0001 -> C=0x8000, S=1, Z=0, P=0, Cout=0, Ov=1. ADD 0xFFFF+0x0001 -> C=0x0000, Z=1, P=1, Cout=1, Ov=0.
- SUB 0x8000-0x0001 -> C=0x7FFF, Ov=1, Cout=1. SUB 0x0000-0x0001 -> C=0xFFFF, S=1, Cout=0, Ov=0, P=1.
- Logic/shift ops on A=0xF0F0, B=0x0FF0:
  - AND -> C=0x00F0, P=1;
  - OR -> C=0xFFF0;
  - XOR -> C=0xFF00;
  - NOT -> C=0x0F0F;
  - SHL -> C=0xE1E0, Cout=1;
  - SHR -> C=0x7878, Cout=0.
- Reset/hold: drop rst_n asynchronously mid-stream -> outputs immediately become C=0, Z=1, P=1, other flags 0. After release with in_valid=0 for 3 cycles, outputs hold and out_valid stays 0.
